// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// | div_pkg : shared types and sizing helpers for the sequential divider     |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

`default_nettype wire

// File: rtl/sub_borrow_nb.sv
// ---------------------------------------------------------------------------
// | sub_borrow_nb : N-bit ripple subtractor (a - b) from full-subtractor     |
// | cells, with borrow out                                                   |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module sub_borrow_nb #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] w_borrow;

  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end

  assign bout = w_borrow[N];

endmodule

`default_nettype wire

// File: rtl/seq_divider_8b.sv
// ---------------------------------------------------------------------------
// | seq_divider_8b : multi-cycle unsigned restoring divider, one quotient    |
// | bit per clock, start/busy/done handshake                                 |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider_8b
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic             w_take;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_count == c_last);

  sub_borrow_nb #(
    .N(WIDTH + 1)
  ) u_trial_sub (
    .a    ({r_rem, r_quo[WIDTH-1]}),
    .b    ({1'b0, r_divisor}),
    .diff (w_trial),
    .bout (w_borrow)
  );

  // The trial MSB is always 0 when there is no borrow; folding it in keeps every bit live.
  assign w_take    = ~w_borrow & ~w_trial[WIDTH];
  assign w_rem_nxt = w_take ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_take};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= divisor;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= dividend;
      r_dbz     <= 1'b0;
      // Divide by zero completes on the accepting edge without iterating.
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_count <= r_count + c_cnt_w'(1);
      if (w_last) begin
        r_quotient  <= w_quo_nxt;
        r_remainder <= w_rem_nxt;
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_8b.sv
// ---------------------------------------------------------------------------
// | tb_seq_divider_8b : scoreboard bench for seq_divider_8b                  |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_8b;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t sb[$];
  exp_t mx;
  logic [7:0] held_q;
  logic [7:0] held_r;
  logic       held_z;

  seq_divider_8b #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on every done, otherwise require held outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          mx = sb.pop_front();
          chk("quotient", {24'd0, quotient}, {24'd0, mx.q});
          chk("remainder", {24'd0, remainder}, {24'd0, mx.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mx.z});
          chk("latency", cyc, mx.e);
          chk("busy_in_done", {31'd0, busy}, 32'd0);
          if (mx.b != 0) begin
            chk("invariant", {31'd0, ((int'(quotient) * int'(mx.b) + int'(remainder)) == int'(mx.a))
                               && (remainder < mx.b)}, 32'd1);
          end
          held_q = mx.q;
          held_r = mx.r;
          held_z = mx.z;
        end
      end else begin
        chk("held_quotient", {24'd0, quotient}, {24'd0, held_q});
        chk("held_remainder", {24'd0, remainder}, {24'd0, held_r});
        chk("held_dbz", {31'd0, div_by_zero}, {31'd0, held_z});
      end
    end
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int e);
    exp_t x;
    x.a = a;
    x.b = b;
    x.z = (b == 0);
    x.q = (b == 0) ? 8'hFF : a / b;
    x.r = (b == 0) ? a : a % b;
    x.e = (b == 0) ? e : e + 8;
    return x;
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc));
    held_z   = 1'b0;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit seen;
    n_checks = 0;
    n_fail   = 0;
    held_q   = 8'd0;
    held_r   = 8'd0;
    held_z   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", {24'd0, quotient}, 32'd0);
    chk("reset_remainder", {24'd0, remainder}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    #2 rst_n = 1'b1;

    // Directed cases, including the boundaries.
    issue(8'd100, 8'd7);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();
    issue(8'd5, 8'd0);
    #2;
    chk("dbz_busy_low", {31'd0, busy}, 32'd0);
    wait_idle();
    issue(8'd255, 8'd1);
    wait_idle();
    issue(8'd3, 8'd200);
    wait_idle();
    issue(8'd255, 8'd255);
    wait_idle();

    // Start during a run must be ignored.
    issue(8'd200, 8'd9);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Back-to-back: start held in the done cycle.
    issue(8'd123, 8'd10);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", {31'd0, seen}, 32'd1);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(posedge clk);
    #1;
    sb.push_back(model(8'd50, 8'd5, cyc));
    held_z = 1'b0;
    start  = 1'b0;
    wait_idle();

    // Reset in the middle of a run.
    issue(8'd77, 8'd4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_quotient", {24'd0, quotient}, 32'd0);
    chk("midreset_remainder", {24'd0, remainder}, 32'd0);
    chk("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    held_q = 8'd0;
    held_r = 8'd0;
    held_z = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd77, 8'd4);
    wait_idle();

    // Random operands, occasional zero divisor.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      issue(ra, rb);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
